// File: rtl/layer_seq_pkg.sv
// Shared types and constants for the dense-layer sequencer: FSM state encoding,
// default widths and saturation bounds used by the requantizer.
package layer_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_WEIGHT_W = 8;
  localparam int DEF_ACC_W    = 32;
  localparam int DEF_CNT_W    = 16;
  localparam int DEF_SHIFT_W  = 5;

  function automatic longint sat_max_f(input int w);
    return (longint'(1) << (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min_f(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

  localparam longint SAT_MAX = sat_max_f(DEF_DATA_W);
  localparam longint SAT_MIN = sat_min_f(DEF_DATA_W);

endpackage

// File: rtl/requant_sat.sv
// Combinational requantizer: arithmetic right shift, saturate to DATA_W signed.
// Define LAYER_SEQ_RELU_EN to additionally clamp negative results to zero.
module requant_sat
  import layer_seq_pkg::*;
#(
  parameter int ACC_W   = DEF_ACC_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SHIFT_W = DEF_SHIFT_W
) (
  input  logic signed [ACC_W-1:0]   acc_i,
  input  logic        [SHIFT_W-1:0] shift_i,
  output logic signed [DATA_W-1:0]  result_o
);

  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(sat_max_f(DATA_W));
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(sat_min_f(DATA_W));

  logic signed [ACC_W-1:0] shifted;
  logic signed [ACC_W-1:0] sat;

  always_comb begin
    shifted = acc_i >>> shift_i;
    if (shifted > MAX_V) begin
      sat = MAX_V;
    end else if (shifted < MIN_V) begin
      sat = MIN_V;
    end else begin
      sat = shifted;
    end
`ifdef LAYER_SEQ_RELU_EN
    if (sat < 0) begin
      sat = '0;
    end
`endif
    result_o = sat[DATA_W-1:0];
  end

endmodule

// File: rtl/layer_sequencer.sv
// Dense-layer controller: streams activation/weight indices, runs a signed MAC
// per neuron and writes the requantized result. ReLU option: LAYER_SEQ_RELU_EN.
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SHIFT_W  = DEF_SHIFT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_mode,
  input  logic        [CNT_W-1:0]    num_in,
  input  logic        [CNT_W-1:0]    num_out,
  input  logic        [31:0]         weight_base,
  input  logic        [SHIFT_W-1:0]  shift,
  input  logic signed [DATA_W-1:0]   data,
  input  logic signed [WEIGHT_W-1:0] weight,
  output logic                       mode,
  output logic        [31:0]         data_idx,
  output logic        [31:0]         weight_idx,
  output logic        [31:0]         result_idx,
  output logic                       write_enable,
  output logic signed [DATA_W-1:0]   result,
  output logic                       busy,
  output logic                       done
);

  state_t state_q, state_d;

  logic                      mode_q, mode_d;
  logic        [31:0]        data_idx_q, data_idx_d;
  logic        [31:0]        weight_idx_q, weight_idx_d;
  logic        [31:0]        result_idx_q, result_idx_d;
  logic                      we_q, we_d;
  logic signed [DATA_W-1:0]  result_q, result_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic        [CNT_W-1:0]   i_q, i_d;
  logic        [CNT_W-1:0]   o_q, o_d;
  logic        [31:0]        wp_q, wp_d;
  logic        [CNT_W-1:0]   num_in_q, num_in_d;
  logic        [CNT_W-1:0]   num_out_q, num_out_d;
  logic        [SHIFT_W-1:0] shift_q, shift_d;
  logic                      rd_valid_q, rd_valid_d;

  logic signed [DATA_W+WEIGHT_W-1:0] prod;
  logic signed [ACC_W-1:0]           acc_sum;
  logic signed [DATA_W-1:0]          req_out;

  assign prod    = data * weight;
  assign acc_sum = rd_valid_q ? (acc_q + ACC_W'(prod)) : acc_q;

  // Fed with the accumulator including the product landing this cycle, so the
  // result can be registered on DRAIN exit and appear alongside write_enable.
  requant_sat #(
    .ACC_W   (ACC_W),
    .DATA_W  (DATA_W),
    .SHIFT_W (SHIFT_W)
  ) u_requant (
    .acc_i    (acc_sum),
    .shift_i  (shift_q),
    .result_o (req_out)
  );

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    data_idx_d   = data_idx_q;
    weight_idx_d = weight_idx_q;
    result_idx_d = result_idx_q;
    result_d     = result_q;
    acc_d        = acc_sum;
    i_d          = i_q;
    o_d          = o_q;
    wp_d         = wp_q;
    num_in_d     = num_in_q;
    num_out_d    = num_out_q;
    shift_d      = shift_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d    = in_mode;
          num_in_d  = num_in;
          num_out_d = num_out;
          shift_d   = shift;
          wp_d      = weight_base;
          i_d       = '0;
          o_d       = '0;
          acc_d     = '0;
          state_d   = ((num_in == '0) || (num_out == '0)) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        data_idx_d   = 32'(i_q);
        weight_idx_d = wp_q;
        i_d          = i_q + CNT_W'(1);
        wp_d         = wp_q + 32'd1;
        if (i_q == num_in_q - CNT_W'(1)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        result_d     = req_out;
        result_idx_d = 32'(o_q);
        state_d      = ST_WRITE;
      end
      ST_WRITE: begin
        acc_d = '0;
        i_d   = '0;
        if (o_q == num_out_q - CNT_W'(1)) begin
          state_d = ST_DONE;
        end else begin
          o_d     = o_q + CNT_W'(1);
          state_d = ST_FETCH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Strobes are decoded from the state being entered so they line up with it.
    rd_valid_d = (state_q == ST_FETCH);
    we_d       = (state_d == ST_WRITE);
    done_d     = (state_d == ST_DONE);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mode_q       <= 1'b0;
      data_idx_q   <= '0;
      weight_idx_q <= '0;
      result_idx_q <= '0;
      we_q         <= 1'b0;
      result_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      acc_q        <= '0;
      i_q          <= '0;
      o_q          <= '0;
      wp_q         <= '0;
      num_in_q     <= '0;
      num_out_q    <= '0;
      shift_q      <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      data_idx_q   <= data_idx_d;
      weight_idx_q <= weight_idx_d;
      result_idx_q <= result_idx_d;
      we_q         <= we_d;
      result_q     <= result_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      acc_q        <= acc_d;
      i_q          <= i_d;
      o_q          <= o_d;
      wp_q         <= wp_d;
      num_in_q     <= num_in_d;
      num_out_q    <= num_out_d;
      shift_q      <= shift_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  assign mode         = mode_q;
  assign data_idx     = data_idx_q;
  assign weight_idx   = weight_idx_q;
  assign result_idx   = result_idx_q;
  assign write_enable = we_q;
  assign result       = result_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Dense-layer controller that drives the ping-pong activation/weight memory: issues read indices, runs a signed MAC over `num_in` inputs per output neuron, and requantizes the accumulator.
- Writes each neuron result back through `result_idx`/`write_enable`; reads return one cycle after the index is driven.
- One `start` processes one full layer. The top level toggles `in_mode` between layers so the output buffer becomes the next layer's input buffer.

Parameters:
- DATA_W, 8, activation/result width (signed two's complement)
- WEIGHT_W, 8, weight width (signed)
- ACC_W, 32, accumulator width
- CNT_W, 16, width of num_in/num_out/counters
- SHIFT_W, 5, width of shift port

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  start-layer pulse, sampled only in IDLE
- in_mode  in  1  buffer select latched at start; 0: read A0/write A1, 1: read A1/write A0
- num_in  in  CNT_W  inputs per neuron, latched at start
- num_out  in  CNT_W  neurons in layer, latched at start
- weight_base  in  32  first weight index of layer, latched at start
- shift  in  SHIFT_W  requant arithmetic right shift, latched at start
- data  in  DATA_W  memory read data (1-cycle latency)
- weight  in  WEIGHT_W  memory read weight (1-cycle latency)
- mode  out  1  to memory; latched in_mode
- data_idx  out  32  activation read index
- weight_idx  out  32  weight read index
- result_idx  out  32  write index
- write_enable  out  1  write strobe
- result  out  DATA_W  requantized neuron output
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at layer end

Behaviour:
- Reset (synchronous): state IDLE. mode, data_idx, weight_idx, result_idx, write_enable, result, busy, done, acc and counters all reset to 0.
- All outputs are registers.
- FSM states: IDLE, FETCH, DRAIN, WRITE, DONE.
- IDLE, start=1:
  - latch parameters; i=0, o=0, acc=0, weight pointer wp=weight_base;
  - if num_in==0 or num_out==0, go to DONE with no writes;
  - else go to FETCH.
- IDLE, start=0: hold. start outside IDLE is ignored.
- FETCH (one cycle per input):
  - drive data_idx=i, weight_idx=wp; set rd_valid=1 for the next cycle.
  - Increment i and wp. wp runs continuously across neurons, so weights are row-major: weight_base + o*num_in + i. No multiplier on the index path.
  - If i==num_in-1, go to DRAIN.
- Accumulate: on every cycle where rd_valid=1, acc <= acc + sext(data)*sext(weight). The multiply is a full DATA_W+WEIGHT_W signed product, sign-extended to ACC_W. Overflow of ACC_W wraps, and the caller sizes layers to avoid it.
- DRAIN: the last product is accumulated; go to WRITE.
- WRITE (one cycle):
  - write_enable=1, result_idx=o, result=requant(acc).
  - Clear acc and i.
  - If o==num_out-1 go to DONE; else o++ and go to FETCH.
- requant:
  - t = acc >>> shift (arithmetic, truncate toward -inf);
  - saturate t to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- DONE: done=1 for one cycle, busy=1; go to IDLE. mode holds its value through IDLE until the next start.
- Latency:
  - start sampled at cycle 0;
  - FETCH cycles 1..N; DRAIN N+1; WRITE N+2;
  - each neuron costs N+2 cycles;
  - done at cycle num_out*(N+2)+1.
- write_enable is 0 in every state except WRITE.
- mode is constant while busy=1.
- Reset mid-operation: next cycle is IDLE with write_enable=0; no partial result is written; acc is cleared.
- Index ranges are not checked. Caller guarantees num_in, num_out and weight_base + num_in*num_out are ≤ memory depth (6400); the bench asserts this.

Optional Feature:
- Macro: LAYER_SEQ_RELU_EN.
- Defined: requant output clamps negatives to 0 after saturation, so results lie in [0, 2^(DATA_W-1)-1].
- Undefined: signed saturated result is passed unchanged.

Decomposition:
- Package layer_seq_pkg: state enum (IDLE/FETCH/DRAIN/WRITE/DONE), default width localparams, and the saturation min/max constants.
- Sub-module requant_sat: combinational shift, saturate and optional ReLU, instantiated once on acc.

Test Plan:
- num_in=3, num_out=1, shift=0, in_mode=0, data A0={1,2,3}, weights {4,5,6} at base 0 -> single write_enable at cycle 5 with result_idx=0, result=32, mode=0; done at cycle 6.
- num_in=4, shift=0, data all 127, weights all 127 -> result 127 (saturated). With weights all -127 -> result -128 (RELU_EN off) or 0 (RELU_EN on).
- num_in=2, num_out=3, weight_base=100 -> weight_idx sequence 100..105 contiguous; result_idx 0,1,2; acc cleared between neurons (check neuron 1 result is independent of neuron 0).
- shift=4, acc=-17 (data -17, weight 1, num_in=1) -> result -2 (floor).
- start with num_in=0, num_out=5 -> no write_enable; done one cycle after IDLE exit.
- rst asserted during FETCH of neuron 1 -> write_enable stays 0, outputs zero next cycle. A new start then runs to completion correctly. Start pulses while busy are ignored.
